mem_stage_dmem_ctrl: RTL and testbench
======================================

Name: mem_stage_dmem_ctrl

Overview:
- Reads the EX/MEM pipeline register outputs for the instruction currently in MEM.
- Runs the data-memory transaction for loads and stores, and stalls the pipeline until that transaction completes.
- Returns load data aligned and sign/zero-extended for the MEM/WB register.
- Sits between the EX/MEM register outputs and the data cache port; its stall output feeds the pipeline-register load enables.

Parameters:
- TIMEOUT, default 256: maximum cycles spent in BUSY before aborting. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  EX/MEM holds a valid (non-bubble) instruction
- opcode  in  7  EX/MEM opcode
- funct3  in  3  EX/MEM funct3
- alu_out  in  32  effective address from the EX/MEM register
- rs2_out  in  32  store data from the EX/MEM register
- advance  in  1  MEM/WB register loads this cycle (instruction leaves MEM)
- dmem_read  out  1  data cache read request
- dmem_write  out  1  data cache write request
- dmem_address  out  32  word-aligned address ({alu_out[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_mbe  out  4  byte enables
- dmem_resp  in  1  cache response, one-cycle pulse
- dmem_rdata  in  32  cache read data, valid with dmem_resp
- mem_stall  out  1  hold the IF/ID, ID/EX, EX/MEM and MEM/WB registers
- load_data  out  32  formatted load result
- misaligned  out  1  one-cycle pulse: misaligned access dropped
- bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Memory op definition:
  - mem_op = mem_valid & (opcode==7'b0000011 load | opcode==7'b0100011 store).
  - Misaligned when: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- States: IDLE, BUSY, DONE. Reset → IDLE. All registered outputs reset to 0: dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe, load_data, misaligned, bus_err. Timeout counter resets to 0.
- IDLE:
  - mem_op & !misaligned → BUSY. On that edge, register address/wdata/mbe and set dmem_read (load) or dmem_write (store).
  - mem_op & misaligned → DONE. misaligned pulses for one cycle; load_data=0; no request is issued.
  - Otherwise stay in IDLE.
- BUSY:
  - Request outputs stay stable until dmem_resp.
  - On dmem_resp: clear requests; if load, register formatted dmem_rdata into load_data; → DONE.
  - Counter increments each BUSY cycle. When TIMEOUT!=0 and counter reaches TIMEOUT-1 without resp: clear requests, load_data=0, pulse bus_err, → DONE.
  - dmem_resp arriving in the same cycle as expiry: the response wins; no bus_err.
- DONE:
  - Outputs hold.
  - advance → IDLE, with the counter cleared.
  - Prevents a held EX/MEM instruction from being reissued.
- mem_stall (combinational) = (IDLE & mem_op) | BUSY. It is 0 in DONE and for non-memory ops.
- Non-memory ops or mem_valid=0 in IDLE: mem_stall=0; load_data is unchanged.
- Latency: minimum 3 cycles from mem_op to stall release (request cycle, response cycle, release). A response in the first BUSY cycle gives 2 stalled cycles.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, mbe=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, mbe=4'b0011<<addr[1:0].
  - SW: wdata=rs2, mbe=4'hF.
  - Reads use mbe=4'hF.
- Load formatting:
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: unchanged.
  - Unknown funct3: treated as LW/SW.
- Reset mid-transaction: immediate return to IDLE with requests deasserted. A late dmem_resp after reset is ignored (IDLE ignores resp).

Decomposition:
- pipe_types package:
  - mem_state_t enum {IDLE, BUSY, DONE}.
  - load_funct3_t / store_funct3_t enums.
  - Opcode constants for load and store (reuse rv32i_types where already present).
- One sub-module, mem_load_align: combinational formatter (dmem_rdata, funct3, addr[1:0] → 32-bit result), instantiated once.
- Store formatting stays in the top module.

Test Plan:
- LW at 0x100, resp after 2 cycles, rdata=0xDEADBEEF → dmem_read=1, address=0x100, mbe=F; load_data=0xDEADBEEF; mem_stall high exactly 3 cycles.
- LB at 0x103, rdata=0x80FF_FFFF → load_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102, rdata=0xBEEF0000 → 0x0000BEEF.
- SB at 0x201, rs2=0x12345678 → address=0x200, wdata=0x78787878, mbe=4'b0010, dmem_write=1. SH at 0x202 → wdata=0x56785678, mbe=4'b1100.
- LW at 0x101 → no dmem_read; misaligned pulses one cycle; load_data=0; mem_stall=0 the following cycle.
- TIMEOUT=4, no resp → bus_err pulses after 4 BUSY cycles; requests drop; DONE; stall releases.
- Instruction held with advance=0 for 5 cycles after completion → exactly one request issued. Reset asserted while in BUSY → dmem_read=0 immediately, state IDLE, next resp ignored.

Source files
------------

// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_stage_dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Byte accesses never misalign; halves need addr[0]=0; everything else
  // (including unknown funct3, which behaves as a word) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic result;
    case (funct3)
      3'b000:  result = 1'b0;
      3'b001:  result = offset[0];
      3'b100:  result = is_store ? (offset != 2'b00) : 1'b0;
      3'b101:  result = is_store ? (offset != 2'b00) : offset[0];
      default: result = (offset != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// Data-cache port between the MEM-stage controller and the cache.
interface mem_stage_dmem_ctrl_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_dmem_ctrl_load_align.sv
// Load formatter: selects byte/half lane from the read word and extends it.
module mem_load_align
  import mem_stage_dmem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by sign/zero extension by funct3.
  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    if (offset[1]) begin
      half_sel = rdata[31:16];
    end else begin
      half_sel = rdata[15:0];
    end
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h000000, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: issues one cache transaction per
// load/store, stalls the pipeline until it completes, formats load data.
module mem_stage_dmem_ctrl
  import mem_stage_dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_valid,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [31:0]                  alu_out,
  input  logic [31:0]                  rs2_out,
  input  logic                         advance,
  mem_stage_dmem_ctrl_if.master        dmem,
  output logic                         mem_stall,
  output logic [31:0]                  load_data,
  output logic                         misaligned,
  output logic                         bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t  state;
  logic [CW-1:0] cnt;
  logic        op_load;
  logic [2:0]  op_funct3;
  logic [1:0]  op_offset;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        mis;
  logic [31:0] st_wdata;
  logic [3:0]  st_mbe;
  logic [31:0] aligned;

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign mem_op   = mem_valid & (is_load | is_store);
  assign mis      = is_misaligned(is_store, funct3, alu_out[1:0]);

  // Held in DONE so a stalled instruction is never reissued.
  assign mem_stall = ((state == IDLE) & mem_op) | (state == BUSY);

  // Store lane replication and byte-enable generation.
  always_comb begin
    st_wdata = rs2_out;
    st_mbe   = 4'hF;
    case (funct3)
      F3_SB: begin
        st_wdata = {4{rs2_out[7:0]}};
        st_mbe   = 4'b0001 << alu_out[1:0];
      end
      F3_SH: begin
        st_wdata = {2{rs2_out[15:0]}};
        st_mbe   = 4'b0011 << alu_out[1:0];
      end
      default: begin
        st_wdata = rs2_out;
        st_mbe   = 4'hF;
      end
    endcase
  end

  // Formatting uses the attributes captured at request time.
  mem_load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .funct3 (op_funct3),
    .offset (op_offset),
    .result (aligned)
  );

  // Transaction FSM with registered request, result and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      op_load           <= 1'b0;
      op_funct3         <= 3'b000;
      op_offset         <= 2'b00;
      dmem.dmem_read    <= 1'b0;
      dmem.dmem_write   <= 1'b0;
      dmem.dmem_address <= 32'h0000_0000;
      dmem.dmem_wdata   <= 32'h0000_0000;
      dmem.dmem_mbe     <= 4'h0;
      load_data         <= 32'h0000_0000;
      misaligned        <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op && mis) begin
            misaligned <= 1'b1;
            load_data  <= 32'h0000_0000;
            state      <= DONE;
          end else if (mem_op) begin
            dmem.dmem_address <= {alu_out[31:2], 2'b00};
            dmem.dmem_wdata   <= st_wdata;
            dmem.dmem_mbe     <= is_load ? 4'hF : st_mbe;
            dmem.dmem_read    <= is_load;
            dmem.dmem_write   <= is_store;
            op_load           <= is_load;
            op_funct3         <= funct3;
            op_offset         <= alu_out[1:0];
            cnt               <= '0;
            state             <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (dmem.dmem_resp) begin
            dmem.dmem_read  <= 1'b0;
            dmem.dmem_write <= 1'b0;
            if (op_load) begin
              load_data <= aligned;
            end
            state <= DONE;
          end else if ((TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1))) begin
            dmem.dmem_read  <= 1'b0;
            dmem.dmem_write <= 1'b0;
            load_data       <= 32'h0000_0000;
            bus_err         <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (advance) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          dmem.dmem_read  <= 1'b0;
          dmem.dmem_write <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed bench for mem_stage_dmem_ctrl (TIMEOUT=4).
module tb_mem_stage_dmem_ctrl;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] RTYPE = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] rs2_out;
  logic        advance;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_writes  = 0;
  logic prev_write = 1'b0;

  mem_stage_dmem_ctrl_if dmem_bus ();

  mem_stage_dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_out    (alu_out),
    .rs2_out    (rs2_out),
    .advance    (advance),
    .dmem       (dmem_bus),
    .mem_stall  (mem_stall),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // Counts write-request rising edges seen by the cache.
  always @(posedge clk) begin
    if (dmem_bus.dmem_write && !prev_write) n_writes++;
    prev_write <= dmem_bus.dmem_write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    mem_valid = 1'b0;
    advance   = 1'b1;
    tick();
    advance   = 1'b0;
  endtask

  // One aligned transaction; response arrives in BUSY cycle resp_cycle.
  task automatic mem_txn(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int resp_cycle,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_mbe);
    int stall_cnt;
    stall_cnt = 0;
    mem_valid = 1'b1; opcode = opc; funct3 = f3; alu_out = addr; rs2_out = rs2; advance = 1'b0;
    #1;
    if (mem_stall) stall_cnt++;
    tick();
    check({tag, "_read"},  {31'd0, dmem_bus.dmem_read},  {31'd0, (opc == LOAD)});
    check({tag, "_write"}, {31'd0, dmem_bus.dmem_write}, {31'd0, (opc == STORE)});
    check({tag, "_addr"},  dmem_bus.dmem_address, exp_addr);
    check({tag, "_mbe"},   {28'd0, dmem_bus.dmem_mbe}, {28'd0, exp_mbe});
    if (opc == STORE) check({tag, "_wdata"}, dmem_bus.dmem_wdata, exp_wdata);
    for (int c = 1; c <= resp_cycle; c++) begin
      if (mem_stall) stall_cnt++;
      if (c == resp_cycle) begin
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = rdata;
      end
      tick();
      dmem_bus.dmem_resp = 1'b0;
    end
    check({tag, "_stall_cycles"}, stall_cnt, resp_cycle + 1);
    check({tag, "_stall_done"}, {31'd0, mem_stall}, 32'd0);
    check({tag, "_req_clear"}, {30'd0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
    check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    alu_out = 32'd0; rs2_out = 32'd0; advance = 1'b0;
    dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = 32'd0;
    tick(); tick();
    check("rst_read",  {31'd0, dmem_bus.dmem_read}, 32'd0);
    check("rst_write", {31'd0, dmem_bus.dmem_write}, 32'd0);
    check("rst_addr",  dmem_bus.dmem_address, 32'd0);
    check("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
    check("rst_mbe",   {28'd0, dmem_bus.dmem_mbe}, 32'd0);
    check("rst_load",  load_data, 32'd0);
    check("rst_pulses", {30'd0, misaligned, bus_err}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    rst = 1'b0;

    // Loads
    mem_txn("lw", LOAD, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 2, 32'h100, 32'd0, 4'hF);
    check("lw_data", load_data, 32'hDEADBEEF);
    retire();
    mem_txn("lb", LOAD, 3'b000, 32'h103, 32'd0, 32'h80FF_FFFF, 1, 32'h100, 32'd0, 4'hF);
    check("lb_data", load_data, 32'hFFFFFF80);
    retire();
    mem_txn("lbu", LOAD, 3'b100, 32'h103, 32'd0, 32'h80FF_FFFF, 1, 32'h100, 32'd0, 4'hF);
    check("lbu_data", load_data, 32'h00000080);
    retire();
    mem_txn("lhu", LOAD, 3'b101, 32'h102, 32'd0, 32'hBEEF0000, 1, 32'h100, 32'd0, 4'hF);
    check("lhu_data", load_data, 32'h0000BEEF);
    retire();
    mem_txn("lh", LOAD, 3'b001, 32'h102, 32'd0, 32'hBEEF0000, 1, 32'h100, 32'd0, 4'hF);
    check("lh_data", load_data, 32'hFFFFBEEF);
    retire();

    // Non-memory instruction: no stall, no request, load_data unchanged
    mem_valid = 1'b1; opcode = RTYPE; funct3 = 3'b000; alu_out = 32'h104;
    #1;
    check("rtype_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("rtype_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
    check("rtype_load", load_data, 32'hFFFFBEEF);
    mem_valid = 1'b0; opcode = LOAD;
    #1;
    check("bubble_stall", {31'd0, mem_stall}, 32'd0);

    // Misaligned LW
    mem_valid = 1'b1; opcode = LOAD; funct3 = 3'b010; alu_out = 32'h101;
    #1;
    check("mis_stall_req", {31'd0, mem_stall}, 32'd1);
    tick();
    check("mis_pulse", {31'd0, misaligned}, 32'd1);
    check("mis_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
    check("mis_load", load_data, 32'd0);
    check("mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("mis_pulse_end", {31'd0, misaligned}, 32'd0);
    check("mis_stall_hold", {31'd0, mem_stall}, 32'd0);
    retire();

    // Stores
    mem_txn("sb", STORE, 3'b000, 32'h201, 32'h12345678, 32'd0, 1, 32'h200, 32'h78787878, 4'b0010);
    retire();
    mem_txn("sh", STORE, 3'b001, 32'h202, 32'h12345678, 32'd0, 1, 32'h200, 32'h56785678, 4'b1100);
    retire();
    mem_txn("sw", STORE, 3'b010, 32'h204, 32'h12345678, 32'd0, 2, 32'h204, 32'h12345678, 4'hF);
    check("sw_load_kept", load_data, 32'd0);
    retire();

    // Response in the same cycle as expiry wins
    mem_txn("lw_late", LOAD, 3'b010, 32'h304, 32'd0, 32'h11223344, 4, 32'h304, 32'd0, 4'hF);
    check("lw_late_data", load_data, 32'h11223344);
    retire();

    // Timeout: four BUSY cycles without response
    mem_valid = 1'b1; opcode = LOAD; funct3 = 3'b010; alu_out = 32'h300;
    tick(); tick(); tick(); tick();
    check("to_busy4_read", {31'd0, dmem_bus.dmem_read}, 32'd1);
    check("to_busy4_stall", {31'd0, mem_stall}, 32'd1);
    check("to_busy4_err", {31'd0, bus_err}, 32'd0);
    tick();
    check("to_err", {31'd0, bus_err}, 32'd1);
    check("to_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
    check("to_load", load_data, 32'd0);
    check("to_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("to_err_end", {31'd0, bus_err}, 32'd0);
    retire();

    // Held instruction after completion is not reissued
    n_writes = 0;
    mem_txn("hold", STORE, 3'b010, 32'h400, 32'hA5A5A5A5, 32'd0, 1, 32'h400, 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_no_req", {30'd0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
      check("hold_stall", {31'd0, mem_stall}, 32'd0);
    end
    check("hold_write_count", n_writes, 1);
    retire();

    // Reset while BUSY, then a stray response
    mem_valid = 1'b1; opcode = LOAD; funct3 = 3'b010; alu_out = 32'h500;
    tick();
    check("rb_read", {31'd0, dmem_bus.dmem_read}, 32'd1);
    mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rb_read_drop", {31'd0, dmem_bus.dmem_read}, 32'd0);
    check("rb_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    rst = 1'b0;
    dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_bus.dmem_resp = 1'b0;
    check("rb_late_load", load_data, 32'd0);
    check("rb_late_req", {30'd0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
    check("rb_late_stall", {31'd0, mem_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
